// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified-memory port arbiter.
//   state_e : transaction FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   gnt_e   : which CPU port owns the current transaction
//   lat_cnt_width / starve_cnt_width : counter widths derived from parameters
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  // Width of the latency down-counter, which holds MEM_LAT-1 .. 0.
  function automatic int lat_cnt_width(input int mem_lat);
    return (mem_lat < 1) ? 1 : $clog2(mem_lat + 1);
  endfunction

  // Width of the starvation counter; at least one bit even when disabled.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int LAT_W_DEFAULT = lat_cnt_width(2);

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between the instruction and data ports.
// Data normally wins; after STARVE_LIMIT consecutive data grants taken while
// an instruction request was waiting, the instruction port is served once.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   if_req     : instruction request pending
//   d_req      : data request pending
//   arb        : a grant is being taken this cycle (arbiter idle with a request)
//   gnt        : selected port
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic arb,
  output gnt_e gnt
);

  localparam int              SC_W      = starve_cnt_width(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_MAX    = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_ZERO   = {SC_W{1'b0}};
  localparam logic [SC_W-1:0] SC_ONE    = SC_W'(1'b1);
  localparam logic            STARVE_EN = (STARVE_LIMIT != 0);

  logic [SC_W-1:0] starve_cnt_r;
  logic [SC_W-1:0] starve_cnt_nx_s;
  gnt_e            gnt_s;

  // Port selection: data first unless the instruction port has waited too long.
  always_comb begin
    gnt_s = GNT_D;
    if (d_req && if_req) begin
      if (STARVE_EN && (starve_cnt_r == SC_MAX)) begin
        gnt_s = GNT_I;
      end else begin
        gnt_s = GNT_D;
      end
    end else if (if_req) begin
      gnt_s = GNT_I;
    end else begin
      gnt_s = GNT_D;
    end
  end

  // Starvation count moves only when a grant is actually taken.
  always_comb begin
    starve_cnt_nx_s = starve_cnt_r;
    if (arb) begin
      if ((gnt_s == GNT_D) && if_req) begin
        if (starve_cnt_r < SC_MAX) begin
          starve_cnt_nx_s = starve_cnt_r + SC_ONE;
        end else begin
          starve_cnt_nx_s = starve_cnt_r;
        end
      end else begin
        starve_cnt_nx_s = SC_ZERO;
      end
    end else begin
      starve_cnt_nx_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= SC_ZERO;
    end else begin
      starve_cnt_r <= starve_cnt_nx_s;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU instruction-fetch port and
// the CPU data port. One transaction at a time: IDLE arbitrates, ACCESS holds
// address/data on the memory for MEM_LAT cycles, RESP pulses ready for one
// cycle to the granted port. All outputs are registered; because the output
// registers reset asynchronously, mem_read/mem_write drop as soon as rst falls.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   if_req/if_adr/if_rdata/if_ready: instruction read port
//   d_req/d_we/d_adr/d_wdata       : data request port
//   d_rdata/d_ready                : data read result / completion pulse
//   mem_adr/mem_wdata/mem_read/mem_write/mem_rdata : memory side
//   busy                           : transaction in flight
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int               LAT_W    = lat_cnt_width(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1'b1);

  state_e           state_r,   state_nx_s;
  gnt_e             gnt_r,     gnt_nx_s;
  gnt_e             gnt_sel_s;
  logic             we_r,      we_nx_s;
  logic [AW-1:0]    adr_r,     adr_nx_s;
  logic [DW-1:0]    wdata_r,   wdata_nx_s;
  logic [LAT_W-1:0] lat_cnt_r, lat_cnt_nx_s;
  logic             arb_s;
  logic             capture_s;
  logic             access_nx_s;

  logic [AW-1:0]    mem_adr_r;
  logic [DW-1:0]    mem_wdata_r;
  logic             mem_read_r;
  logic             mem_write_r;
  logic             if_ready_r;
  logic             d_ready_r;
  logic [DW-1:0]    if_rdata_r;
  logic [DW-1:0]    d_rdata_r;
  logic             busy_r;

  assign arb_s       = (state_r == IDLE) && (if_req || d_req);
  assign capture_s   = (state_r == ACCESS) && (lat_cnt_r == LAT_ZERO);
  assign access_nx_s = (state_nx_s == ACCESS);

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk   (clk),
    .rst_n (rst),
    .if_req(if_req),
    .d_req (d_req),
    .arb   (arb_s),
    .gnt   (gnt_sel_s)
  );

  // Next-state, request latches and latency counter.
  always_comb begin
    state_nx_s   = state_r;
    gnt_nx_s     = gnt_r;
    we_nx_s      = we_r;
    adr_nx_s     = adr_r;
    wdata_nx_s   = wdata_r;
    lat_cnt_nx_s = lat_cnt_r;
    case (state_r)
      IDLE: begin
        if (arb_s) begin
          state_nx_s   = ACCESS;
          gnt_nx_s     = gnt_sel_s;
          lat_cnt_nx_s = LAT_INIT;
          wdata_nx_s   = d_wdata;
          if (gnt_sel_s == GNT_D) begin
            adr_nx_s = d_adr;
            we_nx_s  = d_we;
          end else begin
            adr_nx_s = if_adr;
            we_nx_s  = 1'b0;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS: begin
        if (lat_cnt_r == LAT_ZERO) begin
          state_nx_s = RESP;
        end else begin
          lat_cnt_nx_s = lat_cnt_r - LAT_ONE;
        end
      end
      RESP: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM state and transaction latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      gnt_r     <= GNT_D;
      we_r      <= 1'b0;
      adr_r     <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      lat_cnt_r <= LAT_ZERO;
    end else begin
      state_r   <= state_nx_s;
      gnt_r     <= gnt_nx_s;
      we_r      <= we_nx_s;
      adr_r     <= adr_nx_s;
      wdata_r   <= wdata_nx_s;
      lat_cnt_r <= lat_cnt_nx_s;
    end
  end

  // Output registers decoded from the next state so they line up with it.
  // The write strobe lands only in the last access cycle (next lat_cnt == 0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_adr_r   <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      if_ready_r  <= 1'b0;
      d_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      mem_adr_r   <= access_nx_s ? adr_nx_s : {AW{1'b0}};
      mem_wdata_r <= access_nx_s ? wdata_nx_s : {DW{1'b0}};
      mem_read_r  <= access_nx_s && !we_nx_s;
      mem_write_r <= access_nx_s && we_nx_s && (lat_cnt_nx_s == LAT_ZERO);
      if_ready_r  <= (state_nx_s == RESP) && (gnt_nx_s == GNT_I);
      d_ready_r   <= (state_nx_s == RESP) && (gnt_nx_s == GNT_D);
      busy_r      <= (state_nx_s != IDLE);
    end
  end

  // Read-data capture at the end of the last access cycle; held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_r <= {DW{1'b0}};
      d_rdata_r  <= {DW{1'b0}};
    end else if (capture_s && !we_r) begin
      if (gnt_r == GNT_I) begin
        if_rdata_r <= mem_rdata;
      end else begin
        d_rdata_r <= mem_rdata;
      end
    end
  end

  assign mem_adr   = mem_adr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign if_ready  = if_ready_r;
  assign d_ready   = d_ready_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level schedule model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int AW           = 32;
  localparam int DW           = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_adr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Behavioural memory seen by the DUT, and the model's view of its contents.
  logic [DW-1:0] mem_arr [0:255];
  logic [DW-1:0] ref_mem [0:255];
  assign mem_rdata = mem_arr[mem_adr[9:2]];

  // Transaction-level model: one in-flight transaction granted at edge g.
  int            n = 0;
  bit            act = 1'b0;
  int            g = 0;
  bit            g_d;
  bit            g_we;
  logic [31:0]   g_adr;
  logic [31:0]   g_wdata;
  int            starve = 0;
  int            k = -1;
  bit            exp_acc;
  bit            exp_resp;
  logic [DW-1:0] exp_if_rdata = 32'h0;
  logic [DW-1:0] exp_d_rdata  = 32'h0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  mem_port_arbiter #(
    .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: model arbitration for the coming edge, the edge itself,
  // memory update, then a full output comparison #1 after the edge.
  task automatic tick();
    bit            wr;
    logic [7:0]    wa;
    logic [DW-1:0] wd;
    bit            pick_d;
    wr = (mem_write === 1'b1);
    wa = mem_adr[9:2];
    wd = mem_wdata;
    if (!rst) begin
      act    = 1'b0;
      starve = 0;
    end else if (!act || ((n + 1 - g) >= MEM_LAT + 2)) begin
      act = 1'b0;
      if (d_req || if_req) begin
        pick_d = d_req && !(if_req && (STARVE_LIMIT != 0) && (starve == STARVE_LIMIT));
        if (pick_d && if_req) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
        else starve = 0;
        act     = 1'b1;
        g       = n + 1;
        g_d     = pick_d;
        g_we    = pick_d ? d_we : 1'b0;
        g_adr   = pick_d ? d_adr : if_adr;
        g_wdata = d_wdata;
      end
    end
    @(posedge clk);
    n++;
    if (wr) mem_arr[wa] = wd;
    #1;
    k        = act ? (n - g) : -1;
    exp_acc  = act && (k < MEM_LAT);
    exp_resp = act && (k == MEM_LAT);
    if (exp_resp) begin
      if (g_we) ref_mem[g_adr[9:2]] = g_wdata;
      else if (g_d) exp_d_rdata = ref_mem[g_adr[9:2]];
      else exp_if_rdata = ref_mem[g_adr[9:2]];
    end
    if (mem_write === 1'b1) wr_cnt++;
    if (mem_read === 1'b1) rd_cnt++;
    chk1("busy", busy, exp_acc || exp_resp);
    chk1("mem_read", mem_read, exp_acc && !g_we);
    chk1("mem_write", mem_write, exp_acc && g_we && (k == MEM_LAT - 1));
    chk("mem_adr", mem_adr, exp_acc ? g_adr : 32'h0);
    if (exp_acc && g_we) chk("mem_wdata", mem_wdata, g_wdata);
    chk1("if_ready", if_ready, exp_resp && !g_d);
    chk1("d_ready", d_ready, exp_resp && g_d);
    chk1("ready_exclusive", if_ready && d_ready, 1'b0);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
  endtask

  // Wait (bounded) for a ready pulse on one port; cyc = ticks taken.
  task automatic wait_port(input bit want_d, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(want_d ? d_ready : if_ready) && (cyc < 20));
    chk1(want_d ? "d_ready_seen" : "if_ready_seen", want_d ? d_ready : if_ready, 1'b1);
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear without an edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    act          = 1'b0;
    starve       = 0;
    exp_if_rdata = 32'h0;
    exp_d_rdata  = 32'h0;
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63));
    return a << 2;
  endfunction

  // Random requesters: hold req until ready, sometimes drop mid-access.
  task automatic step_reqs();
    bit in_i;
    bit in_d;
    in_i = act && !g_d && (k < MEM_LAT);
    in_d = act && g_d && (k < MEM_LAT);
    if (exp_resp && !g_d) begin
      if_req = ($urandom_range(0, 1) == 1);
      if_adr = rand_adr();
    end else if (in_i && if_req && ($urandom_range(0, 7) == 0)) begin
      if_req = 1'b0;
    end else if (!if_req && !in_i && ($urandom_range(0, 2) == 0)) begin
      if_req = 1'b1;
      if_adr = rand_adr();
    end
    if (exp_resp && g_d) begin
      d_req   = ($urandom_range(0, 1) == 1);
      d_we    = ($urandom_range(0, 1) == 1);
      d_adr   = rand_adr();
      d_wdata = $urandom;
    end else if (in_d && d_req && ($urandom_range(0, 7) == 0)) begin
      d_req = 1'b0;
    end else if (!d_req && !in_d && ($urandom_range(0, 2) == 0)) begin
      d_req   = 1'b1;
      d_we    = ($urandom_range(0, 1) == 1);
      d_adr   = rand_adr();
      d_wdata = $urandom;
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] wv;
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v          = $urandom;
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    mem_arr[4] = 32'h2002_0005;
    ref_mem[4] = 32'h2002_0005;

    // Reset held with both requests asserted.
    rst = 1'b1; if_req = 1'b0; if_adr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_adr = 32'h0; d_wdata = 32'h0;
    #1;
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1;
    repeat (3) tick();
    chk1("reset_busy", busy, 1'b0);
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    tick();

    // Instruction fetch.
    if_req = 1'b1; if_adr = 32'h0000_0010;
    wr_cnt = 0; rd_cnt = 0;
    wait_port(1'b0, cyc);
    if_req = 1'b0;
    chk("if_latency", cyc, MEM_LAT + 1);
    chk("if_fetch_data", if_rdata, 32'h2002_0005);
    chk("if_read_cycles", rd_cnt, MEM_LAT);
    chk("if_no_write", wr_cnt, 0);
    tick();

    // Data write then read back.
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h0000_03E8; d_wdata = 32'h0000_00AB;
    wr_cnt = 0;
    wait_port(1'b1, cyc);
    d_req = 1'b0;
    chk("d_write_latency", cyc, MEM_LAT + 1);
    chk("d_write_pulses", wr_cnt, 1);
    tick();
    d_req = 1'b1; d_we = 1'b0;
    wait_port(1'b1, cyc);
    d_req = 1'b0;
    chk("d_readback", d_rdata, 32'h0000_00AB);
    tick();

    // Contention: both rise in the same cycle.
    if_req = 1'b1; if_adr = 32'h0000_0020;
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0040;
    wait_port(1'b1, cyc);
    d_req = 1'b0;
    chk("contend_d_latency", cyc, MEM_LAT + 1);
    wait_port(1'b0, cyc);
    if_req = 1'b0;
    chk("contend_i_after_d", cyc, MEM_LAT + 2);
    tick();

    // Starvation: both held high, expect D,D,D,D,I repeating.
    if_req = 1'b1; if_adr = 32'h0000_0030;
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0050;
    for (int i = 0; i < 10; i++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!(if_ready || d_ready) && (cyc < 20));
      chk1("starve_ready_seen", if_ready || d_ready, 1'b1);
      chk1($sformatf("starve_grant%0d_is_d", i), d_ready, (i % 5) != 4);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Reset during a write: first in the strobe cycle, then in the 1st access cycle.
    wv = 32'hC0DE_5A5A;
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h0000_0080; d_wdata = wv;
    tick();
    tick();
    chk1("write_strobe_before_rst", mem_write, 1'b1);
    async_reset();
    tick();
    tick();
    rst = 1'b1;
    wr_cnt = 0;
    tick();
    async_reset();
    tick();
    tick();
    chk("no_write_in_reset", wr_cnt, 0);
    rst = 1'b1;
    wait_port(1'b1, cyc);
    d_req = 1'b0;
    chk("restart_latency", cyc, MEM_LAT + 1);
    chk("restart_write_pulses", wr_cnt, 1);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0080;
    wait_port(1'b1, cyc);
    d_req = 1'b0;
    chk("restart_readback", d_rdata, wv);
    tick();

    // Random traffic against the schedule model.
    for (int i = 0; i < 600; i++) begin
      tick();
      step_reqs();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (MEM_LAT + 3) tick();
    chk1("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port and the CPU data port.
- Serialises accesses and holds address and write data stable for a fixed memory latency.
- Returns read data to the granted requester with a one-cycle ready pulse.
- Sits between the CPU's inst/data buses and a data_mem-style memory; used when instruction and data memories are merged.

Parameters:
- MEM_LAT, 2, memory access cycles per transaction (>=1); read data is sampled at the end of the last access cycle.
- STARVE_LIMIT, 4, maximum consecutive data grants while an instruction request is pending; 0 means strict data priority.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  instruction read request, held until if_ready
- if_adr  in  AW  instruction address
- if_rdata  out  DW  instruction read data, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1=write, 0=read
- d_adr  in  AW  data address
- d_wdata  in  DW  data write value
- d_rdata  out  DW  data read value, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse, data port
- mem_adr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable, sampled by the memory on the clk edge
- mem_rdata  in  DW  memory read data
- busy  out  1  a transaction is in flight (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE, starve_cnt=0.
  - All outputs 0, including if_rdata and d_rdata registers.
  - mem_write and mem_read drop immediately, without waiting for a clock edge.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Arbitrates on each clock edge.
  - Only d_req: grant D.
  - Only if_req: grant I.
  - Both requests: grant D, unless STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, in which case grant I.
  - On a grant: latch adr, we (forced 0 for I), wdata and grant id; set lat_cnt=MEM_LAT-1; go to ACCESS.
  - No request: stay in IDLE with all mem_* = 0.
- starve_cnt (updated only on a grant):
  - D granted while if_req=1: saturating increment.
  - I granted: clear to 0.
  - D granted while if_req=0: clear to 0.
- ACCESS:
  - mem_adr and mem_wdata come from the latches.
  - mem_read = !we for all ACCESS cycles.
  - mem_write = we only in the cycle where lat_cnt==0, giving exactly one write pulse per write.
  - lat_cnt decrements each cycle.
  - At lat_cnt==0 the edge captures mem_rdata into the granted port's rdata register and moves to RESP.
  - For writes, rdata is left unchanged.
- RESP:
  - The granted port's ready=1 for exactly one cycle; the other port's ready=0.
  - mem_* = 0; next state is IDLE.
- Latency: request sampled in IDLE at cycle t -> ready at cycle t+MEM_LAT+1. Back-to-back transactions from one port cost MEM_LAT+2 cycles each.
- Requester rules:
  - adr, we and wdata must stay stable until ready.
  - Dropping req mid-transaction does not abort it: the access completes and the ready pulse is still issued.
  - A req still high during RESP is not re-granted until the following IDLE cycle.
- if_rdata and d_rdata hold their last captured value between transactions.
- Both ready outputs high in the same cycle is illegal and must never occur.
- Reset mid-ACCESS: the transaction is discarded, no ready pulse is issued, and no further mem_write occurs. After release the arbiter starts in IDLE and re-arbitrates pending requests.
- MEM_LAT=1: ACCESS lasts one cycle and mem_write is asserted in that cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - grant id enum {GNT_I, GNT_D}
  - width constant for lat_cnt, sized as $clog2(MEM_LAT+1)
- Sub-module mem_arb_grant: combinational grant selection plus the starve_cnt register. Inputs: if_req, d_req, arbitrate strobe. Output: grant id.
- The FSM, latches and latency counter stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both reqs high -> all outputs 0, busy=0. Assert rst=0 asynchronously mid-cycle -> mem_write falls before the next edge.
- Instruction fetch: MEM_LAT=2, if_adr=0x00000010, memory returns 0x20020005 -> if_ready pulses once at t+3 with if_rdata=0x20020005; mem_read high for 2 cycles; mem_write never asserted.
- Data write then read: write d_adr=0x000003E8, d_wdata=0x000000AB -> one mem_write pulse in the 2nd ACCESS cycle and d_ready at t+3. A following read of 0x3E8 -> d_rdata=0x000000AB.
- Contention: if_req and d_req rise in the same cycle -> d_ready at t+3, then if_ready at t+7; if_rdata is unchanged before t+7.
- Starvation: STARVE_LIMIT=4, d_req and if_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- Reset mid-write: rst=0 in the 1st ACCESS cycle of a write (MEM_LAT=2) -> no mem_write pulse and no d_ready. After release with d_req still high -> the write restarts and d_ready arrives 3 cycles after the first IDLE edge.
